sram_write_checker: RTL and testbench
=====================================

Name: sram_write_checker

Overview:
- Synthesizable, parametrised monitor for the external SRAM write port.
- Taps the address, data and write-enable signals going to the SRAM and records writes into a per-address bitmap covering one configurable region.
- Counts writes outside the region, repeated writes to the same address, and region addresses never written (found by a post-run sweep).
- Folds every write into an order-dependent signature, so a run on the board can be checked against a golden value without a full output dump.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- REGION_LO, 220672, first address of the region that must be written (inclusive).
- REGION_HI, 262144, end of the region (exclusive). DEPTH = REGION_HI-REGION_LO, and DEPTH must be ≥ 1.
- CNT_W, 18, width of every counter. Counters saturate at all-ones.
- SIG_W, 32, signature width. SIG_W must be ≥ DATA_W.

Ports:
- Clock_50  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse: clear bitmap and counters, then begin monitoring.
- Finish  in  1  one-cycle pulse: stop monitoring and sweep the region for unwritten addresses.
- SRAM_address  in  ADDR_W  tapped SRAM address.
- SRAM_write_data  in  DATA_W  tapped SRAM write data.
- SRAM_we_n  in  1  tapped SRAM write enable, active low.
- Busy  out  1  high in S_CLEAR and S_SWEEP.
- Report_valid  out  1  high in S_REPORT.
- Write_count  out  CNT_W  number of in-region writes.
- Out_of_region_count  out  CNT_W  number of writes with address < REGION_LO or ≥ REGION_HI.
- Duplicate_count  out  CNT_W  number of in-region writes to an address already written.
- Unwritten_count  out  CNT_W  number of region addresses never written; valid only when Report_valid is high.
- Signature  out  SIG_W  running write signature.

Behaviour:
- Reset (synchronous, active-high, fixed):
  - State goes to S_CLEAR with the clear pointer at 0.
  - All counters 0, Signature 0, Report_valid 0, Busy 1.
- S_CLEAR:
  - Writes 0 to bitmap[ptr] each cycle; lasts DEPTH cycles.
  - Then goes to S_IDLE.
  - A write strobe seen here is ignored and not counted.
- S_IDLE: on Start go to S_CLEAR and zero all counters and Signature. Finish is ignored.
- S_MONITOR (entered from S_CLEAR when the clear was triggered by Start):
  - A write is a cycle with SRAM_we_n==0.
  - The write is registered into pipe stage 1 (address, data, in-region flag).
  - Stage 2 reads the bitmap bit (1-cycle synchronous read), sets it, and updates the counters. Counter latency is 2 cycles after the strobe.
  - Forwarding: if stage 2 sets address A while stage 1 holds A, stage 1 must see the bit as set. Back-to-back writes to the same address count exactly one duplicate.
  - Out-of-region writes increment only Out_of_region_count and do not touch the bitmap.
  - Signature update on every write, in or out of region: Signature_next = {Signature[SIG_W-2:0], Signature[SIG_W-1]} XOR zero-extend({SRAM_address, SRAM_write_data}), truncated to SIG_W.
  - Finish goes to S_DRAIN.
- S_DRAIN: holds 2 cycles so the pipeline empties, then goes to S_SWEEP. New writes are ignored.
- S_SWEEP:
  - Reads bitmap[ptr] from 0 to DEPTH-1, accounting for read latency.
  - Increments Unwritten_count on each 0.
  - Ends DEPTH+1 cycles after entry, then goes to S_REPORT.
- S_REPORT: outputs hold; Report_valid=1. Start goes to S_CLEAR.
- Start while in S_MONITOR/S_DRAIN/S_SWEEP: abort, go to S_CLEAR, counters zeroed.
- Start and Finish in the same cycle: Start wins.
- Saturation: a counter at all-ones stays there. Signature never saturates.
- Reset mid-operation: full reset, as above.

Optional Feature:
- Macro SRAM_CHECK_FIRST_ERR_EN.
- When defined, adds outputs First_oor_address and First_dup_address (ADDR_W each) plus flags First_oor_valid and First_dup_valid.
- These capture the address of the first out-of-region write and the first duplicate write since the last Start. They reset to 0 / invalid and are cleared on Start.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package sram_check_pkg:
  - state enum (S_CLEAR, S_IDLE, S_MONITOR, S_DRAIN, S_SWEEP, S_REPORT);
  - a saturating-increment function parameterised on CNT_W;
  - the signature-step function.
- Sub-module sram_check_bitmap:
  - DEPTH×1 RAM with one synchronous read port and one write port;
  - write-before-read forwarding is done in the parent.

Test Plan (REGION_LO=16, REGION_HI=24, DEPTH=8 unless stated):
- Reset, Start, then write data i to addresses 16..23, then Finish → Report_valid with Write_count=8, Duplicate_count=0, Unwritten_count=0, Out_of_region_count=0.
- Write only addresses 16,18,20, then Finish → Unwritten_count=5, Write_count=3.
- Back-to-back write cycles to address 17 three times, then Finish → Duplicate_count=2, Write_count=3, Unwritten_count=7.
- Writes to 15 and 24, then 16..23 → Out_of_region_count=2. With SRAM_CHECK_FIRST_ERR_EN defined, First_oor_address=15 and First_oor_valid=1.
- Signature: from 0, write addr 16 data 0x0001 then addr 17 data 0x0002 (ADDR_W=18, DATA_W=16, SIG_W=32) → after the first write 0x00100001; after the second, rotl(0x00100001)=0x00200002 XOR 0x00110002 = 0x00310000.
- CNT_W=2: write 5 out-of-region → Out_of_region_count=3 (saturated). Start mid-sweep → Busy stays high through an 8-cycle S_CLEAR and all counters read 0.

Source files
------------

// File: rtl/sram_check_pkg.sv
// Shared types and helpers for the SRAM write checker: FSM state encoding,
// saturating counter increment and the rotate-XOR signature step.
package sram_check_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_MONITOR,
        S_DRAIN,
        S_SWEEP,
        S_REPORT
    } state_t;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        return (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Values are carried zero-extended in 64 bits; w is the live width.
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] value,
                                                 input int unsigned      w);
        logic [MAX_W-1:0] top;
        top = width_mask(w);
        return (value >= top) ? top : value + 64'd1;
    endfunction

    function automatic logic [MAX_W-1:0] sig_step(input logic [MAX_W-1:0] sig,
                                                  input logic [MAX_W-1:0] word,
                                                  input int unsigned      w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] rot;
        mask = width_mask(w);
        rot  = ((sig << 1) | (sig >> (w - 1))) & mask;
        return (rot ^ word) & mask;
    endfunction

endpackage

// File: rtl/sram_check_bitmap.sv
// DEPTH x 1 written-address bitmap: one synchronous read port, one write port.
// Same-address read/write returns the old bit; the parent forwards around it.
module sram_check_bitmap
    import sram_check_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic             rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic             wr_data
);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sram_write_checker.sv
// Monitors the SRAM write port: region bitmap, error counters, write signature.
// Optional first-error address capture is enabled by SRAM_CHECK_FIRST_ERR_EN.
module sram_write_checker
    import sram_check_pkg::*;
#(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REGION_LO = 220672,
    parameter int unsigned REGION_HI = 262144,
    parameter int unsigned CNT_W     = 18,
    parameter int unsigned SIG_W     = 32
) (
    input  logic              Clock_50,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Finish,
    input  logic [ADDR_W-1:0] SRAM_address,
    input  logic [DATA_W-1:0] SRAM_write_data,
    input  logic              SRAM_we_n,
    output logic              Busy,
    output logic              Report_valid,
    output logic [CNT_W-1:0]  Write_count,
    output logic [CNT_W-1:0]  Out_of_region_count,
    output logic [CNT_W-1:0]  Duplicate_count,
    output logic [CNT_W-1:0]  Unwritten_count,
    output logic [SIG_W-1:0]  Signature
`ifdef SRAM_CHECK_FIRST_ERR_EN
    ,
    output logic [ADDR_W-1:0] First_oor_address,
    output logic [ADDR_W-1:0] First_dup_address,
    output logic              First_oor_valid,
    output logic              First_dup_valid
`endif
);

    localparam int unsigned DEPTH = REGION_HI - REGION_LO;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W:0]  LO       = (ADDR_W+1)'(REGION_LO);
    localparam logic [ADDR_W:0]  HI       = (ADDR_W+1)'(REGION_HI);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(DEPTH);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        logic [MAX_W-1:0] t;
        t = sat_inc(MAX_W'(v), CNT_W);
        return t[CNT_W-1:0];
    endfunction

    function automatic logic [SIG_W-1:0] sig_next(input logic [SIG_W-1:0]         sig,
                                                  input logic [ADDR_W+DATA_W-1:0] word);
        logic [MAX_W-1:0] t;
        t = sig_step(MAX_W'(sig), MAX_W'(word), SIG_W);
        return t[SIG_W-1:0];
    endfunction

    state_t           state, state_next;
    logic [PTR_W-1:0] ptr;
    logic             go_monitor;

    logic             capture, in_region, seen;
    logic [ADDR_W:0]  addr_ext;
    logic [IDX_W-1:0] idx;
    logic             s1_valid, s1_in_region, s1_fwd;
    logic [IDX_W-1:0] s1_idx;
`ifdef SRAM_CHECK_FIRST_ERR_EN
    logic [ADDR_W-1:0] s1_addr;
`endif

    logic             rd_en, rd_data, wr_en, wr_data;
    logic [IDX_W-1:0] rd_addr, wr_addr;

    always_comb begin
        addr_ext  = {1'b0, SRAM_address};
        in_region = (addr_ext >= LO) && (addr_ext < HI);
        idx       = IDX_W'(addr_ext - LO);
        capture   = (state == S_MONITOR) && !SRAM_we_n && !Start;
        seen      = rd_data | s1_fwd;
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state      <= S_CLEAR;
            ptr        <= '0;
            go_monitor <= 1'b0;
        end else begin
            state <= state_next;
            if (Start) begin
                go_monitor <= 1'b1;
            end
            if (Start || state_next != state) begin
                ptr <= '0;
            end else if (state inside {S_CLEAR, S_DRAIN, S_SWEEP}) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (Start) begin
            state_next = S_CLEAR;
        end else begin
            case (state)
                S_CLEAR:   if (ptr == PTR_LAST) state_next = go_monitor ? S_MONITOR : S_IDLE;
                S_MONITOR: if (Finish) state_next = S_DRAIN;
                S_DRAIN:   if (ptr == PTR_ONE) state_next = S_SWEEP;
                S_SWEEP:   if (ptr == PTR_END) state_next = S_REPORT;
                default:   state_next = state;
            endcase
        end
    end

    always_comb begin
        Busy         = (state == S_CLEAR) || (state == S_SWEEP);
        Report_valid = (state == S_REPORT);
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = idx;
        wr_en   = 1'b0;
        wr_addr = s1_idx;
        wr_data = 1'b1;
        case (state)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = IDX_W'(ptr);
                wr_data = 1'b0;
            end
            S_SWEEP: begin
                rd_en   = (ptr < PTR_END);
                rd_addr = IDX_W'(ptr);
            end
            default: begin
                rd_en = capture && in_region;
                wr_en = s1_valid && s1_in_region;
            end
        endcase
    end

    sram_check_bitmap #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bitmap (
        .clk     (Clock_50),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // The bitmap read for a write is issued on its strobe cycle; s1_fwd covers the
    // preceding write to the same index whose bit is only written on that same edge.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= capture;
        end
        s1_in_region <= in_region;
        s1_idx       <= idx;
        s1_fwd       <= s1_valid && s1_in_region && in_region && (s1_idx == idx);
`ifdef SRAM_CHECK_FIRST_ERR_EN
        s1_addr      <= SRAM_address;
`endif
    end

    always_ff @(posedge Clock_50) begin
        if (Reset || Start) begin
            Write_count         <= '0;
            Out_of_region_count <= '0;
            Duplicate_count     <= '0;
            Unwritten_count     <= '0;
            Signature           <= '0;
`ifdef SRAM_CHECK_FIRST_ERR_EN
            First_oor_address   <= '0;
            First_dup_address   <= '0;
            First_oor_valid     <= 1'b0;
            First_dup_valid     <= 1'b0;
`endif
        end else begin
            if (capture) begin
                Signature <= sig_next(Signature, {SRAM_address, SRAM_write_data});
            end
            if (s1_valid) begin
                if (s1_in_region) begin
                    Write_count <= inc(Write_count);
                    if (seen) begin
                        Duplicate_count <= inc(Duplicate_count);
`ifdef SRAM_CHECK_FIRST_ERR_EN
                        if (!First_dup_valid) begin
                            First_dup_valid   <= 1'b1;
                            First_dup_address <= s1_addr;
                        end
`endif
                    end
                end else begin
                    Out_of_region_count <= inc(Out_of_region_count);
`ifdef SRAM_CHECK_FIRST_ERR_EN
                    if (!First_oor_valid) begin
                        First_oor_valid   <= 1'b1;
                        First_oor_address <= s1_addr;
                    end
`endif
                end
            end
            if (state == S_SWEEP && ptr != '0 && !rd_data) begin
                Unwritten_count <= inc(Unwritten_count);
            end
        end
    end

endmodule

// File: tb/tb_sram_write_checker.sv
// Directed bench for sram_write_checker with an 8-entry region (16..23) and a
// second instance using 2-bit counters to exercise saturation.
module tb_sram_write_checker;

    logic        clk = 1'b0;
    logic        rst, start, finish, we_n;
    logic [17:0] addr;
    logic [15:0] wdata;

    logic        busy, rv;
    logic [17:0] wc, oor, dup, unw;
    logic [31:0] sig;
    logic        s_busy, s_rv;
    logic [1:0]  s_wc, s_oor, s_dup, s_unw;
    logic [31:0] s_sig;
`ifdef SRAM_CHECK_FIRST_ERR_EN
    logic [17:0] f_oor_a, f_dup_a, s_f_oor_a, s_f_dup_a;
    logic        f_oor_v, f_dup_v, s_f_oor_v, s_f_dup_v;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_write_checker #(
        .ADDR_W(18), .DATA_W(16), .REGION_LO(16), .REGION_HI(24), .CNT_W(18), .SIG_W(32)
    ) dut (
        .Clock_50(clk), .Reset(rst), .Start(start), .Finish(finish),
        .SRAM_address(addr), .SRAM_write_data(wdata), .SRAM_we_n(we_n),
        .Busy(busy), .Report_valid(rv), .Write_count(wc), .Out_of_region_count(oor),
        .Duplicate_count(dup), .Unwritten_count(unw), .Signature(sig)
`ifdef SRAM_CHECK_FIRST_ERR_EN
        , .First_oor_address(f_oor_a), .First_dup_address(f_dup_a),
        .First_oor_valid(f_oor_v), .First_dup_valid(f_dup_v)
`endif
    );

    sram_write_checker #(
        .ADDR_W(18), .DATA_W(16), .REGION_LO(16), .REGION_HI(24), .CNT_W(2), .SIG_W(32)
    ) dut_sat (
        .Clock_50(clk), .Reset(rst), .Start(start), .Finish(finish),
        .SRAM_address(addr), .SRAM_write_data(wdata), .SRAM_we_n(we_n),
        .Busy(s_busy), .Report_valid(s_rv), .Write_count(s_wc), .Out_of_region_count(s_oor),
        .Duplicate_count(s_dup), .Unwritten_count(s_unw), .Signature(s_sig)
`ifdef SRAM_CHECK_FIRST_ERR_EN
        , .First_oor_address(s_f_oor_a), .First_dup_address(s_f_dup_a),
        .First_oor_valid(s_f_oor_v), .First_dup_valid(s_f_dup_v)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL busy_timeout: Busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic wait_busy_high();
        int n = 0;
        while (busy !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL sweep_timeout: Busy %b after %0d cycles, required 1", busy, n);
        end
    endtask

    task automatic start_run();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_busy_low(n);
    endtask

    task automatic finish_run();
        int n = 0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        while (rv !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (rv !== 1'b1) begin errors++; $display("FAIL report_valid: got %b required 1", rv); end
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we_n  = 1'b0;
        tick();
        we_n  = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; start = 1'b0; finish = 1'b0; we_n = 1'b1; addr = '0; wdata = '0;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b required 1", busy); end
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b required 0", rv); end
        checks++; if (wc !== 18'd0) begin errors++; $display("FAIL rst_wc: got %0d required 0", wc); end
        checks++; if (oor !== 18'd0) begin errors++; $display("FAIL rst_oor: got %0d required 0", oor); end
        checks++; if (dup !== 18'd0) begin errors++; $display("FAIL rst_dup: got %0d required 0", dup); end
        checks++; if (unw !== 18'd0) begin errors++; $display("FAIL rst_unw: got %0d required 0", unw); end
        checks++; if (sig !== 32'd0) begin errors++; $display("FAIL rst_sig: got %h required 0", sig); end
        rst = 1'b0;
        wait_busy_low(n);
        checks++; if (n != 8) begin errors++; $display("FAIL rst_clear_len: got %0d required 8", n); end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        repeat (20) tick();
        checks++; if (rv !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_finish: got rv=%b busy=%b required 0/0", rv, busy);
        end
    endtask

    task automatic test_full_region();
        start_run();
        for (int i = 0; i < 8; i++) wr(18'(16 + i), 16'(i));
        finish_run();
        checks++; if (wc !== 18'd8) begin errors++; $display("FAIL full_wc: got %0d required 8", wc); end
        checks++; if (dup !== 18'd0) begin errors++; $display("FAIL full_dup: got %0d required 0", dup); end
        checks++; if (unw !== 18'd0) begin errors++; $display("FAIL full_unw: got %0d required 0", unw); end
        checks++; if (oor !== 18'd0) begin errors++; $display("FAIL full_oor: got %0d required 0", oor); end
    endtask

    task automatic test_sparse();
        start_run();
        wr(18'd16, 16'h0);
        tick();
        wr(18'd18, 16'h1);
        wr(18'd20, 16'h2);
        finish_run();
        checks++; if (unw !== 18'd5) begin errors++; $display("FAIL sparse_unw: got %0d required 5", unw); end
        checks++; if (wc !== 18'd3) begin errors++; $display("FAIL sparse_wc: got %0d required 3", wc); end
        checks++; if (dup !== 18'd0) begin errors++; $display("FAIL sparse_dup: got %0d required 0", dup); end
    endtask

    task automatic test_back_to_back();
        start_run();
        wr(18'd17, 16'hA);
        wr(18'd17, 16'hB);
        wr(18'd17, 16'hC);
        finish_run();
        checks++; if (dup !== 18'd2) begin errors++; $display("FAIL b2b_dup: got %0d required 2", dup); end
        checks++; if (wc !== 18'd3) begin errors++; $display("FAIL b2b_wc: got %0d required 3", wc); end
        checks++; if (unw !== 18'd7) begin errors++; $display("FAIL b2b_unw: got %0d required 7", unw); end
`ifdef SRAM_CHECK_FIRST_ERR_EN
        checks++; if (f_dup_v !== 1'b1 || f_dup_a !== 18'd17) begin
            errors++; $display("FAIL first_dup: got v=%b a=%0d required 1/17", f_dup_v, f_dup_a);
        end
`endif
    endtask

    task automatic test_out_of_region();
        start_run();
        wr(18'd15, 16'h1);
        wr(18'd24, 16'h2);
        for (int i = 0; i < 8; i++) wr(18'(16 + i), 16'(i));
        finish_run();
        checks++; if (oor !== 18'd2) begin errors++; $display("FAIL oor_cnt: got %0d required 2", oor); end
        checks++; if (wc !== 18'd8) begin errors++; $display("FAIL oor_wc: got %0d required 8", wc); end
        checks++; if (unw !== 18'd0) begin errors++; $display("FAIL oor_unw: got %0d required 0", unw); end
`ifdef SRAM_CHECK_FIRST_ERR_EN
        checks++; if (f_oor_v !== 1'b1 || f_oor_a !== 18'd15) begin
            errors++; $display("FAIL first_oor: got v=%b a=%0d required 1/15", f_oor_v, f_oor_a);
        end
        checks++; if (f_dup_v !== 1'b0) begin errors++; $display("FAIL first_dup_clr: got %b required 0", f_dup_v); end
`endif
    endtask

    task automatic test_signature();
        start_run();
        checks++; if (sig !== 32'd0) begin errors++; $display("FAIL sig_start: got %h required 0", sig); end
        wr(18'd16, 16'h0001);
        checks++; if (sig !== 32'h0010_0001) begin errors++; $display("FAIL sig_1: got %h required 00100001", sig); end
        checks++; if (wc !== 18'd0) begin errors++; $display("FAIL lat_wc0: got %0d required 0", wc); end
        wr(18'd17, 16'h0002);
        checks++; if (sig !== 32'h0031_0000) begin errors++; $display("FAIL sig_2: got %h required 00310000", sig); end
        checks++; if (wc !== 18'd1) begin errors++; $display("FAIL lat_wc1: got %0d required 1", wc); end
        tick();
        checks++; if (wc !== 18'd2) begin errors++; $display("FAIL lat_wc2: got %0d required 2", wc); end
        checks++; if (sig !== 32'h0031_0000) begin errors++; $display("FAIL sig_hold: got %h required 00310000", sig); end
    endtask

    task automatic test_saturation();
        start_run();
        for (int i = 0; i < 5; i++) wr(18'd0, 16'(i));
        finish_run();
        checks++; if (oor !== 18'd5) begin errors++; $display("FAIL sat_wide_oor: got %0d required 5", oor); end
        checks++; if (s_oor !== 2'd3) begin errors++; $display("FAIL sat_oor: got %0d required 3", s_oor); end
        checks++; if (unw !== 18'd8) begin errors++; $display("FAIL sat_wide_unw: got %0d required 8", unw); end
        checks++; if (s_unw !== 2'd3) begin errors++; $display("FAIL sat_unw: got %0d required 3", s_unw); end
        checks++; if (s_rv !== 1'b1) begin errors++; $display("FAIL sat_rv: got %b required 1", s_rv); end
    endtask

    task automatic test_abort();
        int n;
        start_run();
        wr(18'd16, 16'h5);
        wr(18'd3, 16'h6);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        wait_busy_high();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (wc !== 18'd0 || oor !== 18'd0 || unw !== 18'd0 || sig !== 32'd0) begin
            errors++; $display("FAIL abort_zero: got wc=%0d oor=%0d unw=%0d sig=%h required all 0", wc, oor, unw, sig);
        end
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL abort_rv: got %b required 0", rv); end
        addr = 18'd16;
        we_n = 1'b0;
        wait_busy_low(n);
        we_n = 1'b1;
        checks++; if (n != 8) begin errors++; $display("FAIL abort_clear_len: got %0d required 8", n); end
        finish_run();
        checks++; if (wc !== 18'd0) begin errors++; $display("FAIL clear_write_ignored: got %0d required 0", wc); end
        checks++; if (unw !== 18'd8) begin errors++; $display("FAIL abort_unw: got %0d required 8", unw); end
    endtask

    initial begin
        test_reset();
        test_full_region();
        test_sparse();
        test_back_to_back();
        test_out_of_region();
        test_signature();
        test_saturation();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
